// File: rtl/freq_seg_scan_if.sv
// Display bus of the frequency seven-segment scanner: packed BCD word in,
// active-low digit enables and active-high segments out.
interface freq_seg_scan_if;
  logic [31:0] freq_data;
  logic [7:0]  an;
  logic [7:0]  seg;

  modport master (output freq_data, input an, input seg);
  modport slave  (input freq_data, output an, output seg);
endinterface

// File: rtl/freq_seg_scan.sv
// 8-digit multiplexed seven-segment driver for the packed BCD frequency word.
// Optional leading-zero blanking per 4-digit group via FREQ_SEG_LZB_EN.
module freq_seg_scan #(
  parameter int SCAN_DIV = 10
) (
  input  logic            clk_10k,
  input  logic            rst,
  freq_seg_scan_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic [2:0]       idx_reg;
  logic [31:0]      snap_reg;
  logic [7:0]       an_reg, an_next;
  logic [7:0]       seg_reg, seg_next;

  logic [3:0] nib [8];
  logic [7:0] nz;
  logic [7:0] blank;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign nib[gi] = snap_reg[4*gi +: 4];
      assign nz[gi]  = |snap_reg[4*gi +: 4];
    end
  endgenerate

`ifdef FREQ_SEG_LZB_EN
  // A digit goes dark only when it and every more significant digit of its
  // group are zero; the units digits of each group always show.
  assign blank[7] = ~nz[7];
  assign blank[6] = ~|nz[7:6];
  assign blank[5] = ~|nz[7:5];
  assign blank[4] = 1'b0;
  assign blank[3] = ~nz[3];
  assign blank[2] = ~|nz[3:2];
  assign blank[1] = ~|nz[3:1];
  assign blank[0] = 1'b0;
`else
  assign blank = 8'h00;
`endif

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // div==0 is the dead-time slot; digits never overlap.
  always_comb begin
    an_next  = 8'hFF;
    seg_next = 8'h00;
    if (div_reg != '0) begin
      an_next       = ~(8'b1 << idx_reg);
      seg_next[6:0] = blank[idx_reg] ? 7'h00 : dec7(nib[idx_reg]);
      seg_next[7]   = (idx_reg == 3'd4);
    end
  end

  always_ff @(posedge clk_10k) begin
    if (rst) begin
      div_reg  <= '0;
      idx_reg  <= 3'd0;
      snap_reg <= 32'h0;
      an_reg   <= 8'hFF;
      seg_reg  <= 8'h00;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      if (div_reg == '0 && idx_reg == 3'd0)
        snap_reg <= bus.freq_data;
      if (div_reg == DIV_LAST) begin
        div_reg <= '0;
        idx_reg <= idx_reg + 3'd1;
      end else begin
        div_reg <= div_reg + 1'b1;
      end
    end
  end

  assign bus.an  = an_reg;
  assign bus.seg = seg_reg;

endmodule

// File: tb/tb_freq_seg_scan.sv
// Scoreboard bench for freq_seg_scan: expected an/seg per cycle are queued
// when each frame's word is driven and compared as the scan plays out.
module tb_freq_seg_scan;

  localparam int SCAN_DIV = 10;
  localparam int FRAME    = 8 * SCAN_DIV;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  logic clk_10k = 1'b0;
  logic rst;

  freq_seg_scan_if bus ();

  freq_seg_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk_10k (clk_10k),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_10k = ~clk_10k;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q   [$];
  logic [31:0] frame_q [$];
  logic [31:0] mid_q   [$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] model(input logic [31:0] v, input int slot, input int d);
    logic [7:0] an_e;
    logic [7:0] seg_e;
    logic       blank;
    logic [3:0] nb;
    if (d == 0) return 16'hFF00;
    blank = 1'b0;
`ifdef FREQ_SEG_LZB_EN
    if (slot != 4 && slot != 0) begin
      blank = 1'b1;
      for (int k = slot; k <= ((slot > 4) ? 7 : 3); k++)
        if (v[4*k +: 4] != 4'h0) blank = 1'b0;
    end
`endif
    nb    = v[4*slot +: 4];
    an_e  = ~(8'h01 << slot);
    seg_e = {(slot == 4), blank ? 7'h00 : SEG_TBL[nb]};
    return {an_e, seg_e};
  endfunction

  task automatic push_frame(input logic [31:0] v);
    for (int s = 0; s < 8; s++)
      for (int d = 0; d < SCAN_DIV; d++)
        exp_q.push_back(model(v, s, d));
  endtask

  // Called at a negedge with rst high; releases reset, runs ncyc checked
  // cycles, then asserts reset again at a negedge.
  task automatic run_frames(input int ncyc);
    int f;
    logic [15:0] e;
    exp_q.delete();
    rst = 1'b0;
    bus.freq_data = frame_q[0];
    push_frame(frame_q[0]);
    for (int m = 0; m < ncyc; m++) begin
      @(negedge clk_10k);
      if (exp_q.size() == 0) begin
        check("sb_empty", 16'(exp_q.size()), 16'h1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("scan m%0d", m), {bus.an, bus.seg}, e);
      end
      check("onehot", {15'h0, ($countones(~bus.an) <= 1)}, 16'h1);
      f = m / FRAME;
      if (m % FRAME == 30 && f < mid_q.size() && mid_q[f] != 32'h0)
        bus.freq_data = mid_q[f];
      if (m % FRAME == FRAME - 1) begin
        $display("frame %0d word %h scanned", f, frame_q[f]);
        if (f + 1 < frame_q.size()) begin
          bus.freq_data = frame_q[f + 1];
          push_frame(frame_q[f + 1]);
        end
      end
    end
    rst = 1'b1;
  endtask

  task automatic check_dark(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_10k);
      check("reset_dark", {bus.an, bus.seg}, 16'hFF00);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.freq_data = 32'h0;
    check_dark(3);

    // Scan order, mid-frame coherence, invalid BCD, blanking pattern.
    frame_q = '{32'h12345678, 32'h12345678, 32'h11111111, 32'h22222222,
                32'h0000000F, 32'h00500007};
    mid_q   = '{32'h0, 32'h0, 32'h22222222, 32'h0, 32'h0, 32'h0};
    run_frames(6 * FRAME);
    check_dark(3);

    // Reset in the middle of a frame, then a fresh scan.
    frame_q = '{32'h12345678};
    mid_q.delete();
    run_frames(45);
    check_dark(3);
    frame_q = '{32'h87654321, 32'h0A0B0C0D};
    run_frames(2 * FRAME);
    check_dark(1);

    // Random words.
    frame_q.delete();
    for (int i = 0; i < 100; i++) frame_q.push_back($urandom);
    run_frames(100 * FRAME);
    check_dark(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
